data_mem_rv32: RTL
==================

# data_mem_rv32

Byte-addressable RV32I data memory with byte-lane stores, sign/zero-extended loads, misalignment detection and a valid/ready request handshake with configurable wait states. It sits in the MEM stage between the ALU address output and the writeback mux. It supersedes the single-register data path with a real storage array of `DEPTH` words. One request is outstanding at a time. With `WAIT_STATES = 0` it sustains one access per cycle.

## Interface
- `WIDTH`, 32, data/address width; only 32 is supported.
- `DEPTH`, 1024, number of 32-bit words; power of two. `AW = clog2(DEPTH)`.
- `WAIT_STATES`, 0, extra cycles inserted between request acceptance and response (0..15).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu. Other codes are illegal.
- `addr`  in  WIDTH  byte address.
- `wdata`  in  WIDTH  store data, right-aligned.
- `rdata`  out  WIDTH  load result, extended to 32 bits.
- `rvalid`  out  1  response strobe, one cycle per accepted request.
- `misaligned`  out  1  error flag, valid only while `rvalid = 1`.

## Operation
- **Accept:** a request is accepted when `req_valid && req_ready`. `we`, `funct3`, `addr` and `wdata` are registered at acceptance.
- **Word index:** `addr[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH`. Lane is `addr[1:0]`.
- **Error conditions:**
  - halfword access with `addr[0] = 1`;
  - word access with `addr[1:0] != 0`;
  - illegal `funct3`.
- **Error response:** no array write, `rdata = 0`, `misaligned = 1` together with `rvalid`.
- **Stores:**
  - sb writes `wdata[7:0]` to lane `addr[1:0]`.
  - sh writes `wdata[15:0]` to lanes `{addr[1],0}` and `{addr[1],1}`.
  - sw writes all 4 lanes.
  - Unwritten lanes are preserved.
  - A store response is `rvalid = 1` with `rdata = 0`.
- **Loads:**
  - lb/lbu select the byte at the lane; lb sign-extends from bit 7, lbu zero-extends.
  - lh/lhu select the halfword at `addr[1]`; lh sign-extends from bit 15, lhu zero-extends.
  - lw returns the full word.
- **Commit point:** the array write and the read capture both happen on the edge that enters RESP, using the registered request fields.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: `req_ready = 1`. On accept, go to RESP if `WAIT_STATES = 0`; otherwise go to WAIT and load the counter with `WAIT_STATES - 1`.
  - WAIT: `req_ready = 0`. Decrement the counter; when it is 0, go to RESP on the next edge.
  - RESP: `rvalid = 1` for exactly one cycle and `req_ready = 1`. An accept here follows the same rule as in IDLE; with no accept, go to IDLE.
- **Ordering:** responses are in request order. A load after a store to the same word always returns the stored data, including back-to-back.
- **Array contents:** not reset and not initialised; the bench must write before reading.

## Timing
- **Reset values** (asynchronous on `rst` rising, held while high): state = IDLE, `req_ready = 0` while `rst = 1` and `1` after release, `rvalid = 0`, `rdata = 0`, `misaligned = 0`, counter = 0.
- **Latency:** accept edge to `rvalid` high = `1 + WAIT_STATES` cycles. `rdata` and `misaligned` are registered and stable for the `rvalid` cycle.
- **Throughput:** 1 request/cycle at `WAIT_STATES = 0`; otherwise 1 per `1 + WAIT_STATES` cycles.
- **Outputs outside RESP:** `rdata` is 0 and `misaligned` is 0 when `rvalid = 0`.
- **Request inputs:** changes to request inputs while `req_ready = 0` are ignored. The requester holds `req_valid` until accepted.
- **Reset mid-request:** the pending request is dropped. A store not yet at its commit edge is not written, and no response is issued.

## Test plan
- `WAIT_STATES = 0`: sw `0xDEADBEEF` @`0x10`, then lw @`0x10` back-to-back -> second `rvalid` 2 cycles after the first accept, `rdata = 0xDEADBEEF`, `misaligned = 0`.
- sb `0x80` @`0x11` onto word `0x00000000`, then lb @`0x11` -> `0xFFFFFF80`; lbu @`0x11` -> `0x00000080`; lw @`0x10` -> `0x00008000`.
- sh `0x8001` @`0x22`, then lh @`0x22` -> `0xFFFF8001`; lhu -> `0x00008001`; lanes 0–1 of word `0x20` unchanged.
- lw @`0x13` and sh @`0x21` -> `rvalid` with `misaligned = 1`, `rdata = 0`; a subsequent lw @`0x20` shows no write occurred. `funct3 = 011` also flags.
- `WAIT_STATES = 3`: lw accepted at cycle 0 -> `req_ready` low cycles 1–3, `rvalid` at cycle 4. Address `4*DEPTH + 0x10` hits the same word as `0x10`.
- `WAIT_STATES = 3`: assert `rst` during WAIT of a sw -> no `rvalid`, all outputs 0, and a later lw shows the old word unchanged.

Source files
------------

// File: rtl/data_mem_rv32.sv
// RV32I MEM-stage data memory: byte-lane stores, extended loads, misalignment
// flagging, valid/ready request handshake with optional wait states.
module data_mem_rv32 #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = AW + 2;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES == 0) ? '0 : CW'(WAIT_STATES - 1);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef struct packed {
    logic             we;
    logic [2:0]       funct3;
    logic [BW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  req_t             req_q;
  req_t             req_in;
  req_t             cmt;
  logic             accept;
  logic             enter_resp;
  logic             err;
  logic             wr_en;
  logic [1:0]       lane;
  logic [AW-1:0]    idx;
  logic [3:0]       be;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] wd_lane;
  logic [WIDTH-1:0] ld;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             unused_addr;

  logic [WIDTH-1:0] mem [DEPTH];

  // Addresses wrap modulo 4*DEPTH; the high bits are intentionally dropped.
  assign unused_addr = ^addr[WIDTH-1:BW];

  always_comb begin
    req_in        = '0;
    req_in.we     = we;
    req_in.funct3 = funct3;
    req_in.addr   = addr[BW-1:0];
    req_in.wdata  = wdata;
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == '0));

  // With no wait states the commit edge is the accept edge, so the live request is used.
  assign cmt  = (state == S_WAIT) ? req_q : req_in;
  assign lane = cmt.addr[1:0];
  assign idx  = cmt.addr[BW-1:2];
  assign cur  = mem[idx];

  always_comb begin
    err = 1'b0;
    be  = 4'b0000;
    case (cmt.funct3)
      F_B, F_BU: be = 4'b0001 << lane;
      F_H, F_HU: begin
        err = lane[0];
        be  = lane[1] ? 4'b1100 : 4'b0011;
      end
      F_W: begin
        err = (lane != 2'b00);
        be  = 4'b1111;
      end
      default: err = 1'b1;
    endcase
  end

  assign wd_lane = cmt.wdata << {lane, 3'b000};
  assign half_v  = lane[1] ? cur[31:16] : cur[15:0];
  assign wr_en   = enter_resp && cmt.we && !err;

  always_comb begin
    byte_v = cur[7:0];
    case (lane)
      2'd0:    byte_v = cur[7:0];
      2'd1:    byte_v = cur[15:8];
      2'd2:    byte_v = cur[23:16];
      default: byte_v = cur[31:24];
    endcase
  end

  always_comb begin
    ld = '0;
    case (cmt.funct3)
      F_B:     ld = {{24{byte_v[7]}}, byte_v};
      F_BU:    ld = {24'd0, byte_v};
      F_H:     ld = {{16{half_v[15]}}, half_v};
      F_HU:    ld = {16'd0, half_v};
      F_W:     ld = cur;
      default: ld = '0;
    endcase
  end

  // Storage array: byte-enabled writes, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_lane[8*b +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_q      <= '0;
      req_ready  <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
    end else begin
      rvalid     <= enter_resp;
      rdata      <= '0;
      misaligned <= 1'b0;
      req_ready  <= 1'b1;
      if (enter_resp) begin
        misaligned <= err;
        rdata      <= (err || cmt.we) ? '0 : ld;
      end
      if (accept) req_q <= req_in;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state     <= S_WAIT;
              cnt       <= WAIT_LOAD;
              req_ready <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt       <= cnt - CW'(1);
            req_ready <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
